cr_cddip_pipe_tracker: RTL and testbench
========================================

Name: cr_cddip_pipe_tracker

Overview:
Parametrised, multi-channel successor to the supervisor pipe-occupancy logic. Per channel it tracks three command counts: requests in the pipe, requests still in the input stream formatter (ISF), and completions awaiting exit. Counters saturate, and over/underflow is flagged as a sticky error. It also provides debounced idle, registered interrupt, a halt FSM with explicit release, and per-channel high-water marks. Sits in the CDDIP support block between the ISF/OSF event strobes and the status, interrupt and halt consumers.

Parameters:
NUM_CH, 2, number of independent channels (1..8)
CNT_W, 8, counter width in bits (4..16)
IDLE_DLY, 4, consecutive all-empty cycles required before idle asserts (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
isf_sup_rqe_rx  in  NUM_CH  per-channel request entering pipe (pulse)
isf_sup_cqe_exit  in  NUM_CH  per-channel request leaving ISF
isf_sup_cqe_rx  in  NUM_CH  per-channel completion generated
osf_sup_cqe_exit  in  NUM_CH  per-channel completion leaving OSF
pre_cddip_int  in  1  raw interrupt request
halt_release  in  1  pulse: release halt
stat_clr  in  1  pulse: clear sticky errors and high-water marks
pipe_cmds  out  NUM_CH*CNT_W  pipe counts, ch0 in LSBs
isf_cmds  out  NUM_CH*CNT_W  ISF counts
cqe_cmds  out  NUM_CH*CNT_W  completion counts
pipe_hwm  out  NUM_CH*CNT_W  pipe high-water marks
data_busy / isf_busy / comp_busy  out  NUM_CH each  counter != 0
cnt_ovf  out  NUM_CH  sticky overflow, any counter of the channel
cnt_udf  out  NUM_CH  sticky underflow
cddip_int  out  1  registered interrupt
sup_osf_halt  out  1  halt to OSF
cddip_idle  out  1  debounced idle

Behaviour:
- Reset: all counters, HWMs, errors, idle count 0. cddip_int=0, sup_osf_halt=0, cddip_idle=0, FSM=RUN.
- Counter update, per channel and counter, one-cycle latency. pipe: inc=rqe_rx, dec=osf_cqe_exit. isf: inc=rqe_rx, dec=isf_cqe_exit. cqe: inc=cqe_rx, dec=osf_cqe_exit.
  - Both or neither asserted: hold.
  - Inc only: +1. If the counter equals all-ones, hold at max and set cnt_ovf[ch].
  - Dec only: -1. If the counter is 0, hold at 0 and set cnt_udf[ch].
  - Counters never wrap.
- Busy outputs are combinational from the registered counters.
- HWM: pipe_hwm[ch] <= max(pipe_hwm[ch], next pipe count), so it tracks the registered count in the same cycle.
- stat_clr: clears cnt_ovf, cnt_udf and sets each HWM to the current registered count.
  - stat_clr has priority over a same-cycle error set: error cleared, the event is lost.
  - Counters are not affected by stat_clr.
- Idle: idle_cnt (8b) increments, saturating at IDLE_DLY, while every pipe counter == 0; it resets to 0 otherwise.
  - cddip_idle <= (idle_cnt == IDLE_DLY).
  - First idle assertion comes IDLE_DLY+1 cycles after the counts reach zero.
  - cddip_idle deasserts the cycle after any pipe counter becomes non-zero.
- cddip_int <= pre_cddip_int (one-cycle delay, no stickiness).
- Halt FSM:
  - RUN: sup_osf_halt=0; goes to HALT when pre_cddip_int=1.
  - HALT: sup_osf_halt=1; goes to RUN when halt_release=1 and pre_cddip_int=0.
  - halt_release while pre_cddip_int=1 is ignored.
  - sup_osf_halt is registered, so it rises one cycle after pre_cddip_int.
- Halt does not gate counting. Events during halt are still tracked.
- Async reset mid-operation clears everything immediately. No event is remembered.

Test Plan:
- CNT_W=8, ch0: 3 rqe_rx pulses, then 3 osf_cqe_exit -> pipe_cmds[7:0] goes 1,2,3,2,1,0; pipe_hwm[7:0]=3; data_busy[0] low after the last exit; cddip_idle rises IDLE_DLY+1=5 cycles later.
- ch1: rqe_rx and osf_cqe_exit asserted in the same cycle with count=2 -> count stays 2, no error.
- CNT_W=4: 16 rqe_rx pulses on ch0 -> count saturates at 15, cnt_ovf[0]=1 sticky; stat_clr -> cnt_ovf[0]=0, pipe_hwm=15.
- osf_cqe_exit on ch1 with pipe and cqe at 0 -> counters stay 0, cnt_udf[1]=1, ch0 flags unaffected.
- Halt sequence:
  - pre_cddip_int high for 2 cycles -> cddip_int and sup_osf_halt high 1 cycle later.
  - halt_release while pre=1 -> halt stays high.
  - pre=0 then halt_release -> halt low next cycle.
- Assert rst_n low with counts 5/3/2 and the FSM in HALT -> all outputs 0 and the FSM in RUN; after release, counting resumes from 0.

Source files
------------

// File: rtl/cr_cddip_pipe_tracker.sv
// Per-channel CDDIP pipe occupancy tracker with saturating counters,
// sticky errors, high-water marks, debounced idle and a halt FSM.
//
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   isf_sup_rqe_rx    : per-channel request entering the pipe
//   isf_sup_cqe_exit  : per-channel request leaving the ISF
//   isf_sup_cqe_rx    : per-channel completion generated
//   osf_sup_cqe_exit  : per-channel completion leaving the OSF
//   pre_cddip_int     : raw interrupt request
//   halt_release      : pulse, release halt
//   stat_clr          : pulse, clear sticky errors and reload HWMs
//   pipe/isf/cqe_cmds : packed counters, ch0 in the LSBs
//   pipe_hwm          : packed pipe high-water marks
//   data/isf/comp_busy: counter non-zero flags
//   cnt_ovf/cnt_udf   : sticky overflow / underflow per channel
//   cddip_int         : registered interrupt
//   sup_osf_halt      : halt to the OSF
//   cddip_idle        : debounced idle
module cr_cddip_pipe_tracker #(
  parameter int NUM_CH   = 2,
  parameter int CNT_W    = 8,
  parameter int IDLE_DLY = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       isf_sup_rqe_rx,
  input  logic [NUM_CH-1:0]       isf_sup_cqe_exit,
  input  logic [NUM_CH-1:0]       isf_sup_cqe_rx,
  input  logic [NUM_CH-1:0]       osf_sup_cqe_exit,
  input  logic                    pre_cddip_int,
  input  logic                    halt_release,
  input  logic                    stat_clr,
  output logic [NUM_CH*CNT_W-1:0] pipe_cmds,
  output logic [NUM_CH*CNT_W-1:0] isf_cmds,
  output logic [NUM_CH*CNT_W-1:0] cqe_cmds,
  output logic [NUM_CH*CNT_W-1:0] pipe_hwm,
  output logic [NUM_CH-1:0]       data_busy,
  output logic [NUM_CH-1:0]       isf_busy,
  output logic [NUM_CH-1:0]       comp_busy,
  output logic [NUM_CH-1:0]       cnt_ovf,
  output logic [NUM_CH-1:0]       cnt_udf,
  output logic                    cddip_int,
  output logic                    sup_osf_halt,
  output logic                    cddip_idle
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;
  localparam logic [7:0] IDLE_MAX = 8'(IDLE_DLY);

  // Result is {ovf, udf, next}; saturating, never wraps.
  function automatic logic [CNT_W+1:0] f_step(
    input logic [CNT_W-1:0] c,
    input logic             inc,
    input logic             dec
  );
    f_step = {2'b00, c};
    if (inc && !dec) begin
      if (&c) f_step[CNT_W+1] = 1'b1;
      else    f_step[CNT_W-1:0] = c + 1'b1;
    end else if (dec && !inc) begin
      if (c == '0) f_step[CNT_W] = 1'b1;
      else         f_step[CNT_W-1:0] = c - 1'b1;
    end
  endfunction

  logic [NUM_CH-1:0] w_ovf_set;
  logic [NUM_CH-1:0] w_udf_set;
  logic [NUM_CH-1:0] w_pzero;
  logic              w_all_zero;
  logic [NUM_CH-1:0] r_ovf;
  logic [NUM_CH-1:0] r_udf;
  logic [7:0]        r_idle_cnt;
  logic              r_idle;
  logic              r_int;
  logic [0:0]        r_state;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W+1:0] w_p;
    logic [CNT_W+1:0] w_i;
    logic [CNT_W+1:0] w_c;
    logic [CNT_W-1:0] r_pipe;
    logic [CNT_W-1:0] r_isf;
    logic [CNT_W-1:0] r_cqe;
    logic [CNT_W-1:0] r_hwm;

    assign w_p = f_step(r_pipe, isf_sup_rqe_rx[g],
                        osf_sup_cqe_exit[g]);
    assign w_i = f_step(r_isf, isf_sup_rqe_rx[g],
                        isf_sup_cqe_exit[g]);
    assign w_c = f_step(r_cqe, isf_sup_cqe_rx[g],
                        osf_sup_cqe_exit[g]);

    assign w_ovf_set[g] = w_p[CNT_W+1] | w_i[CNT_W+1] |
                          w_c[CNT_W+1];
    assign w_udf_set[g] = w_p[CNT_W] | w_i[CNT_W] |
                          w_c[CNT_W];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pipe <= '0;
        r_isf  <= '0;
        r_cqe  <= '0;
        r_hwm  <= '0;
      end else begin
        r_pipe <= w_p[CNT_W-1:0];
        r_isf  <= w_i[CNT_W-1:0];
        r_cqe  <= w_c[CNT_W-1:0];
        // Clear reloads the mark from the count as it stands now.
        if (stat_clr)
          r_hwm <= r_pipe;
        else if (w_p[CNT_W-1:0] > r_hwm)
          r_hwm <= w_p[CNT_W-1:0];
      end
    end

    assign pipe_cmds[g*CNT_W +: CNT_W] = r_pipe;
    assign isf_cmds[g*CNT_W +: CNT_W]  = r_isf;
    assign cqe_cmds[g*CNT_W +: CNT_W]  = r_cqe;
    assign pipe_hwm[g*CNT_W +: CNT_W]  = r_hwm;
    assign data_busy[g] = |r_pipe;
    assign isf_busy[g]  = |r_isf;
    assign comp_busy[g] = |r_cqe;
    assign w_pzero[g]   = (r_pipe == '0);
  end

  assign w_all_zero = &w_pzero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else if (stat_clr) begin
      r_ovf <= '0;
      r_udf <= '0;
    end else begin
      r_ovf <= r_ovf | w_ovf_set;
      r_udf <= r_udf | w_udf_set;
    end
  end

  // Qualifying with w_all_zero drops idle on the first busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= 8'd0;
      r_idle     <= 1'b0;
    end else begin
      r_idle <= (r_idle_cnt == IDLE_MAX) && w_all_zero;
      if (!w_all_zero)
        r_idle_cnt <= 8'd0;
      else if (r_idle_cnt != IDLE_MAX)
        r_idle_cnt <= r_idle_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int   <= 1'b0;
      r_state <= ST_RUN;
    end else begin
      r_int <= pre_cddip_int;
      unique case (r_state)
        ST_RUN:
          if (pre_cddip_int) r_state <= ST_HALT;
        ST_HALT:
          if (halt_release && !pre_cddip_int)
            r_state <= ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign cnt_ovf      = r_ovf;
  assign cnt_udf      = r_udf;
  assign cddip_int    = r_int;
  assign sup_osf_halt = (r_state == ST_HALT);
  assign cddip_idle   = r_idle;

endmodule

// File: tb/tb_cr_cddip_pipe_tracker.sv
// Scoreboard bench for cr_cddip_pipe_tracker: a behavioural model
// queues expected outputs per cycle; outputs are popped after the edge.
module tb_cr_cddip_pipe_tracker;

  localparam int NUM_CH   = 2;
  localparam int CNT_W    = 4;
  localparam int IDLE_DLY = 4;
  localparam int W        = NUM_CH * CNT_W;
  localparam int MAXC     = (1 << CNT_W) - 1;

  logic              clk;
  logic              rst_n;
  logic [NUM_CH-1:0] isf_sup_rqe_rx;
  logic [NUM_CH-1:0] isf_sup_cqe_exit;
  logic [NUM_CH-1:0] isf_sup_cqe_rx;
  logic [NUM_CH-1:0] osf_sup_cqe_exit;
  logic              pre_cddip_int;
  logic              halt_release;
  logic              stat_clr;
  logic [W-1:0]      pipe_cmds;
  logic [W-1:0]      isf_cmds;
  logic [W-1:0]      cqe_cmds;
  logic [W-1:0]      pipe_hwm;
  logic [NUM_CH-1:0] data_busy;
  logic [NUM_CH-1:0] isf_busy;
  logic [NUM_CH-1:0] comp_busy;
  logic [NUM_CH-1:0] cnt_ovf;
  logic [NUM_CH-1:0] cnt_udf;
  logic              cddip_int;
  logic              sup_osf_halt;
  logic              cddip_idle;

  cr_cddip_pipe_tracker #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .IDLE_DLY(IDLE_DLY)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .isf_sup_rqe_rx(isf_sup_rqe_rx),
    .isf_sup_cqe_exit(isf_sup_cqe_exit),
    .isf_sup_cqe_rx(isf_sup_cqe_rx),
    .osf_sup_cqe_exit(osf_sup_cqe_exit),
    .pre_cddip_int(pre_cddip_int),
    .halt_release(halt_release),
    .stat_clr(stat_clr),
    .pipe_cmds(pipe_cmds), .isf_cmds(isf_cmds),
    .cqe_cmds(cqe_cmds), .pipe_hwm(pipe_hwm),
    .data_busy(data_busy), .isf_busy(isf_busy),
    .comp_busy(comp_busy),
    .cnt_ovf(cnt_ovf), .cnt_udf(cnt_udf),
    .cddip_int(cddip_int), .sup_osf_halt(sup_osf_halt),
    .cddip_idle(cddip_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]      pipe;
    logic [W-1:0]      isf;
    logic [W-1:0]      cqe;
    logic [W-1:0]      hwm;
    logic [NUM_CH-1:0] db;
    logic [NUM_CH-1:0] ib;
    logic [NUM_CH-1:0] cb;
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] udf;
    logic              intr;
    logic              halt;
    logic              idle;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_err;

  int          m_pc[NUM_CH];
  int          m_ic[NUM_CH];
  int          m_cc[NUM_CH];
  int          m_hw[NUM_CH];
  logic [NUM_CH-1:0] m_ovf;
  logic [NUM_CH-1:0] m_udf;
  int          m_idc;
  bit          m_idle;
  bit          m_int;
  bit          m_halt;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_pc[c] = 0; m_ic[c] = 0; m_cc[c] = 0; m_hw[c] = 0;
    end
    m_ovf = '0; m_udf = '0;
    m_idc = 0; m_idle = 0; m_int = 0; m_halt = 0;
    q.delete();
  endtask

  task automatic cnt_step(input int c, input bit inc,
                          input bit dec, output int n,
                          output bit ov, output bit un);
    n = c; ov = 0; un = 0;
    if (inc && !dec) begin
      if (c == MAXC) ov = 1; else n = c + 1;
    end else if (dec && !inc) begin
      if (c == 0) un = 1; else n = c - 1;
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit az;
    int np, ni, nc;
    bit o1, o2, o3, u1, u2, u3;
    az = 1;
    for (int c = 0; c < NUM_CH; c++)
      if (m_pc[c] != 0) az = 0;
    m_idle = (m_idc == IDLE_DLY) && az;
    if (!az) m_idc = 0;
    else if (m_idc < IDLE_DLY) m_idc++;
    for (int c = 0; c < NUM_CH; c++) begin
      cnt_step(m_pc[c], isf_sup_rqe_rx[c],
               osf_sup_cqe_exit[c], np, o1, u1);
      cnt_step(m_ic[c], isf_sup_rqe_rx[c],
               isf_sup_cqe_exit[c], ni, o2, u2);
      cnt_step(m_cc[c], isf_sup_cqe_rx[c],
               osf_sup_cqe_exit[c], nc, o3, u3);
      if (stat_clr) m_hw[c] = m_pc[c];
      else if (np > m_hw[c]) m_hw[c] = np;
      m_ovf[c] = stat_clr ? 1'b0 : (m_ovf[c] | o1 | o2 | o3);
      m_udf[c] = stat_clr ? 1'b0 : (m_udf[c] | u1 | u2 | u3);
      m_pc[c] = np; m_ic[c] = ni; m_cc[c] = nc;
    end
    m_int = pre_cddip_int;
    if (!m_halt && pre_cddip_int) m_halt = 1;
    else if (m_halt && halt_release && !pre_cddip_int)
      m_halt = 0;
    e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      e.pipe[c*CNT_W +: CNT_W] = CNT_W'(m_pc[c]);
      e.isf[c*CNT_W +: CNT_W]  = CNT_W'(m_ic[c]);
      e.cqe[c*CNT_W +: CNT_W]  = CNT_W'(m_cc[c]);
      e.hwm[c*CNT_W +: CNT_W]  = CNT_W'(m_hw[c]);
      e.db[c] = (m_pc[c] != 0);
      e.ib[c] = (m_ic[c] != 0);
      e.cb[c] = (m_cc[c] != 0);
    end
    e.ovf = m_ovf; e.udf = m_udf;
    e.intr = m_int; e.halt = m_halt; e.idle = m_idle;
    q.push_back(e);
  endtask

  task automatic cyc(input logic [NUM_CH-1:0] rq,
                     input logic [NUM_CH-1:0] ie,
                     input logic [NUM_CH-1:0] cr,
                     input logic [NUM_CH-1:0] oe,
                     input logic pre, input logic rel,
                     input logic clr);
    exp_t e;
    @(negedge clk);
    isf_sup_rqe_rx   = rq;
    isf_sup_cqe_exit = ie;
    isf_sup_cqe_rx   = cr;
    osf_sup_cqe_exit = oe;
    pre_cddip_int    = pre;
    halt_release     = rel;
    stat_clr         = clr;
    model_step();
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk("sb_empty", 64'd1, 64'd0);
    end else begin
      e = q.pop_front();
      chk("pipe", 64'(pipe_cmds), 64'(e.pipe));
      chk("isf", 64'(isf_cmds), 64'(e.isf));
      chk("cqe", 64'(cqe_cmds), 64'(e.cqe));
      chk("hwm", 64'(pipe_hwm), 64'(e.hwm));
      chk("busy", 64'({data_busy, isf_busy, comp_busy}),
          64'({e.db, e.ib, e.cb}));
      chk("ovf", 64'(cnt_ovf), 64'(e.ovf));
      chk("udf", 64'(cnt_udf), 64'(e.udf));
      chk("int", 64'(cddip_int), 64'(e.intr));
      chk("halt", 64'(sup_osf_halt), 64'(e.halt));
      chk("idle", 64'(cddip_idle), 64'(e.idle));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pipe"}, 64'(pipe_cmds), 64'd0);
    chk({tag, "_isf"}, 64'(isf_cmds), 64'd0);
    chk({tag, "_cqe"}, 64'(cqe_cmds), 64'd0);
    chk({tag, "_hwm"}, 64'(pipe_hwm), 64'd0);
    chk({tag, "_flags"},
        64'({cnt_ovf, cnt_udf, data_busy, comp_busy}), 64'd0);
    chk({tag, "_int"}, 64'(cddip_int), 64'd0);
    chk({tag, "_halt"}, 64'(sup_osf_halt), 64'd0);
    chk({tag, "_idle"}, 64'(cddip_idle), 64'd0);
  endtask

  initial begin
    int n;
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0;
    isf_sup_rqe_rx = '0; isf_sup_cqe_exit = '0;
    isf_sup_cqe_rx = '0; osf_sup_cqe_exit = '0;
    pre_cddip_int = 0; halt_release = 0; stat_clr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    rst_n = 1'b1;

    // ch0: three requests in, three out
    for (int i = 1; i <= 3; i++) begin
      cyc(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
      chk("t1_up", 64'(pipe_cmds[3:0]), 64'(i));
    end
    for (int i = 2; i >= 0; i--) begin
      cyc(2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 0);
      chk("t1_dn", 64'(pipe_cmds[3:0]), 64'(i));
    end
    chk("t1_hwm", 64'(pipe_hwm[3:0]), 64'd3);
    chk("t1_busy", 64'(data_busy[0]), 64'd0);
    n = 0;
    while (!cddip_idle && n < 20) begin
      cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
      n++;
    end
    chk("t1_idle_lat", 64'(n), 64'(IDLE_DLY + 1));

    // ch1: simultaneous inc/dec holds at 2
    repeat (2) cyc(2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
    cyc(2'b10, 2'b00, 2'b10, 2'b10, 0, 0, 0);
    chk("t2_hold", 64'(pipe_cmds[7:4]), 64'd2);
    chk("t2_noerr", 64'({cnt_ovf, cnt_udf}), 64'd0);
    chk("t2_idle", 64'(cddip_idle), 64'd0);
    repeat (2) cyc(2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0);

    // ch1 underflow with pipe and cqe empty
    cyc(2'b00, 2'b00, 2'b00, 2'b10, 0, 0, 0);
    chk("t4_cnt1", 64'({pipe_cmds[7:4], cqe_cmds[7:4]}), 64'd0);
    chk("t4_udf", 64'(cnt_udf), 64'b10);
    chk("t4_ovf", 64'(cnt_ovf), 64'd0);

    // ch0 saturation and clear
    repeat (16) cyc(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("t3_sat", 64'(pipe_cmds[3:0]), 64'd15);
    chk("t3_ovf", 64'(cnt_ovf), 64'b01);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("t3_sticky", 64'(cnt_ovf), 64'b01);
    cyc(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 1);
    chk("t3_clr", 64'({cnt_ovf, cnt_udf}), 64'd0);
    chk("t3_hwm", 64'(pipe_hwm[3:0]), 64'd15);
    repeat (15) cyc(2'b00, 2'b01, 2'b00, 2'b01, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 1);

    // halt sequence
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    chk("h_int", 64'(cddip_int), 64'd1);
    chk("h_halt", 64'(sup_osf_halt), 64'd1);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
    chk("h_ign_rel", 64'(sup_osf_halt), 64'd1);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("h_int_lo", 64'(cddip_int), 64'd0);
    chk("h_still", 64'(sup_osf_halt), 64'd1);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
    chk("h_rel", 64'(sup_osf_halt), 64'd0);

    // counts 5/3/2 on ch0, halt, then async reset
    repeat (2) cyc(2'b01, 2'b00, 2'b01, 2'b00, 0, 0, 0);
    repeat (3) cyc(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    repeat (2) cyc(2'b00, 2'b01, 2'b00, 2'b00, 0, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 1, 0, 0);
    cyc(2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("r_pre", 64'({pipe_cmds[3:0], isf_cmds[3:0],
        cqe_cmds[3:0], 3'b000, sup_osf_halt}), 64'h5321);
    #1 rst_n = 1'b0;
    #1;
    chk_all_zero("arst");
    model_reset();
    #1 rst_n = 1'b1;
    cyc(2'b01, 2'b00, 2'b00, 2'b00, 0, 0, 0);
    chk("r_resume", 64'(pipe_cmds[3:0]), 64'd1);
    chk("r_run", 64'(sup_osf_halt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
